// File: rtl/mem_port_arbiter_pkg.sv
// Shared definitions for the two-requester memory port arbiter:
// state encoding, requester ids and the data path width.
package mem_port_arbiter_pkg;

   localparam int DATA_W = 32;

   // State encoding
   localparam logic [1:0] IDLE = 2'd0;
   localparam logic [1:0] BUSY = 2'd1;
   localparam logic [1:0] ACK  = 2'd2;

   // Requester ids, also the value driven on the mux select line
   localparam logic REQ_A = 1'b0;
   localparam logic REQ_B = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE = IDLE,
      ST_BUSY = BUSY,
      ST_ACK  = ACK
   } state_t;

   // The requester that did not win last time
   function automatic logic other_req(input logic id);
      return (id == REQ_A) ? REQ_B : REQ_A;
   endfunction

endpackage

// File: rtl/mem_port_arbiter_arb_rr2.sv
// Combinational 2-way tie-break for the memory port arbiter.
// Default build: round-robin on a tie (the requester that was not
// granted last wins). With MEM_ARB_FIXED_PRIO_EN defined, A always
// wins a tie. A lone request is granted the same way in both modes.
module arb_rr2
   import mem_port_arbiter_pkg::*;
(
   input  logic ReqA,
   input  logic ReqB,
   input  logic last_grant,
   output logic grant
);

`ifdef MEM_ARB_FIXED_PRIO_EN
   // last_grant is kept in the port list so both builds share one interface
   logic unused_last_grant;
   assign unused_last_grant = last_grant;

   // Fixed priority: instruction fetch (A) first
   always_comb begin
      grant = REQ_A;
      if (!ReqA && ReqB) begin
         grant = REQ_B;
      end
   end
`else
   // Round-robin: on a tie, grant whoever was not served last
   always_comb begin
      grant = REQ_A;
      if (ReqA && ReqB) begin
         grant = other_req(last_grant);
      end else if (ReqB) begin
         grant = REQ_B;
      end
   end
`endif

endmodule

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single shared 32-bit memory port.
// Grants one requester, drives the address/write-data mux select,
// holds MemEn for MEM_LATENCY cycles, then returns read data with a
// one-cycle acknowledge. Optional macro: MEM_ARB_FIXED_PRIO_EN selects
// fixed priority (A wins ties) instead of round-robin.
//
// Handshake: ReqX is a level held by the requester until AckX. The
// arbiter samples requests only in IDLE. AckX is a single-cycle pulse
// in the ACK state; the requester must drop ReqX by the edge that ends
// that cycle or it will be seen as a new request. Wr is sampled with
// the grant; changes of Req/Wr during BUSY are ignored.
module mem_port_arbiter
   import mem_port_arbiter_pkg::*;
#(
   parameter int MEM_LATENCY = 2,
   parameter int CNT_W       = 4
)(
   input  logic              Clk,
   input  logic              Reset_n,
   input  logic              ReqA,
   input  logic              WrA,
   input  logic              ReqB,
   input  logic              WrB,
   input  logic [DATA_W-1:0] MemRData,
   output logic              Sel,
   output logic              MemEn,
   output logic              MemWr,
   output logic              AckA,
   output logic              AckB,
   output logic [DATA_W-1:0] RData,
   output logic [1:0]        dbg_state
);

   // Counter load value: BUSY lasts MEM_LATENCY cycles, ending at zero
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

   state_t              state;
   state_t              state_nxt;
   logic [CNT_W-1:0]    cnt;
   logic [CNT_W-1:0]    cnt_nxt;
   logic                last_grant;
   logic                last_grant_nxt;
   logic                grant;
   logic                sel_nxt;
   logic                mem_en_nxt;
   logic                mem_wr_nxt;
   logic                ack_a_nxt;
   logic                ack_b_nxt;
   logic [DATA_W-1:0]   rdata_nxt;

   arb_rr2 u_arb (
      .ReqA       (ReqA),
      .ReqB       (ReqB),
      .last_grant (last_grant),
      .grant      (grant)
   );

   assign dbg_state = state;

   // Next-state and next-output logic; every output is registered below
   always_comb begin
      state_nxt      = state;
      cnt_nxt        = cnt;
      last_grant_nxt = last_grant;
      sel_nxt        = Sel;
      mem_en_nxt     = MemEn;
      mem_wr_nxt     = MemWr;
      ack_a_nxt      = 1'b0;
      ack_b_nxt      = 1'b0;
      rdata_nxt      = RData;

      case (state)
         ST_IDLE: begin
            if (ReqA || ReqB) begin
               sel_nxt        = grant;
               mem_wr_nxt     = (grant == REQ_B) ? WrB : WrA;
               mem_en_nxt     = 1'b1;
               cnt_nxt        = CNT_LOAD;
               last_grant_nxt = grant;
               state_nxt      = ST_BUSY;
            end
         end

         ST_BUSY: begin
            if (cnt != '0) begin
               cnt_nxt = cnt - 1'b1;
            end else begin
               // Read data is valid on the last BUSY cycle; writes keep RData
               if (!MemWr) begin
                  rdata_nxt = MemRData;
               end
               ack_a_nxt  = (Sel == REQ_A);
               ack_b_nxt  = (Sel == REQ_B);
               mem_en_nxt = 1'b0;
               mem_wr_nxt = 1'b0;
               state_nxt  = ST_ACK;
            end
         end

         ST_ACK: begin
            // Requests are ignored here; Sel holds until the next grant
            state_nxt = ST_IDLE;
         end

         default: begin
            mem_en_nxt = 1'b0;
            mem_wr_nxt = 1'b0;
            state_nxt  = ST_IDLE;
         end
      endcase
   end

   // State, counter and registered outputs; reset abandons any access
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state      <= ST_IDLE;
         cnt        <= '0;
         last_grant <= REQ_B;
         Sel        <= REQ_A;
         MemEn      <= 1'b0;
         MemWr      <= 1'b0;
         AckA       <= 1'b0;
         AckB       <= 1'b0;
         RData      <= '0;
      end else begin
         state      <= state_nxt;
         cnt        <= cnt_nxt;
         last_grant <= last_grant_nxt;
         Sel        <= sel_nxt;
         MemEn      <= mem_en_nxt;
         MemWr      <= mem_wr_nxt;
         AckA       <= ack_a_nxt;
         AckB       <= ack_b_nxt;
         RData      <= rdata_nxt;
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: a cycle-by-cycle vector table
// for MEM_LATENCY=2, hand sequences for reset mid-access, and a second
// instance built with MEM_LATENCY=1. Tie expectations follow
// MEM_ARB_FIXED_PRIO_EN when it is defined.
module tb_mem_port_arbiter;

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_BUSY = 2'd1;
   localparam logic [1:0] S_ACK  = 2'd2;

`ifdef MEM_ARB_FIXED_PRIO_EN
   localparam logic TIE2 = 1'b0;  // second tie goes to A again
`else
   localparam logic TIE2 = 1'b1;  // second tie goes to B
`endif

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   // ---------------- DUT, MEM_LATENCY=2 ----------------
   logic        req_a = 0, wr_a = 0, req_b = 0, wr_b = 0;
   logic [31:0] mrd = '0;
   logic        sel, mem_en, mem_wr, ack_a, ack_b;
   logic [31:0] rdata;
   logic [1:0]  st;

   mem_port_arbiter #(.MEM_LATENCY(2), .CNT_W(4)) dut (
      .Clk(clk), .Reset_n(rst_n), .ReqA(req_a), .WrA(wr_a), .ReqB(req_b), .WrB(wr_b),
      .MemRData(mrd), .Sel(sel), .MemEn(mem_en), .MemWr(mem_wr), .AckA(ack_a),
      .AckB(ack_b), .RData(rdata), .dbg_state(st)
   );

   // ---------------- DUT, MEM_LATENCY=1 ----------------
   logic        req_a1 = 0, wr_a1 = 0, req_b1 = 0, wr_b1 = 0;
   logic [31:0] mrd1 = '0;
   logic        sel1, mem_en1, mem_wr1, ack_a1, ack_b1;
   logic [31:0] rdata1;
   logic [1:0]  st1;

   mem_port_arbiter #(.MEM_LATENCY(1), .CNT_W(4)) dut1 (
      .Clk(clk), .Reset_n(rst_n), .ReqA(req_a1), .WrA(wr_a1), .ReqB(req_b1), .WrB(wr_b1),
      .MemRData(mrd1), .Sel(sel1), .MemEn(mem_en1), .MemWr(mem_wr1), .AckA(ack_a1),
      .AckB(ack_b1), .RData(rdata1), .dbg_state(st1)
   );

   // ---------------- scoreboard ----------------
   int checks = 0;
   int errors = 0;

   task automatic chk1(input string name, input logic act, input logic exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%b expected=%b", name, act, exp);
      end
   endtask

   task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Invariants sampled every cycle away from the active edge
   always @(negedge clk) begin
      if (rst_n) begin
         chk1("ack_exclusive", ack_a & ack_b, 1'b0);
         chk1("en_only_busy", mem_en & (st != S_BUSY), 1'b0);
         chk1("ack_exclusive_l1", ack_a1 & ack_b1, 1'b0);
         chk1("en_only_busy_l1", mem_en1 & (st1 != S_BUSY), 1'b0);
      end
   end

   // ---------------- vector table ----------------
   typedef struct {
      logic        ra, wa, rb, wb;
      logic [31:0] mrd;
      logic [1:0]  st;
      logic        sel, en, wr, aa, ab;
      logic [31:0] rd;
   } vec_t;

   vec_t vecs[$];

   task automatic add(input logic ra, wa, rb, wb, input logic [31:0] m,
                      input logic [1:0] s, input logic sl, en, wr, aa, ab,
                      input logic [31:0] rd);
      vec_t v;
      v.ra = ra; v.wa = wa; v.rb = rb; v.wb = wb; v.mrd = m;
      v.st = s; v.sel = sl; v.en = en; v.wr = wr; v.aa = aa; v.ab = ab; v.rd = rd;
      vecs.push_back(v);
   endtask

   // One full 4-cycle access with both/one requests held, read data m.
   // g is the expected grant, w the expected write flag.
   task automatic add_access(input logic ra, wa, rb, wb, input logic ra_end, rb_end,
                             input logic [31:0] m, input logic g, w,
                             input logic [31:0] rd_before, input logic [31:0] rd_after);
      add(ra, wa, rb, wb, m,         S_BUSY, g, 1, w, 0, 0, rd_before);
      add(ra, wa, rb, wb, m,         S_BUSY, g, 1, w, 0, 0, rd_before);
      add(ra, wa, rb, wb, m,         S_ACK,  g, 0, 0, !g, g, rd_after);
      add(ra_end, wa, rb_end, wb, m, S_IDLE, g, 0, 0, 0, 0, rd_after);
   endtask

   initial begin
      // idle
      add(0,0,0,0, 32'h0, S_IDLE, 0,0,0,0,0, 32'h0);
      // single read A
      add_access(1,0,0,0, 0,0, 32'hDEADBEEF, 0, 0, 32'h0, 32'hDEADBEEF);
      // single write B: RData keeps prior value
      add_access(0,0,1,1, 0,0, 32'h12345678, 1, 1, 32'hDEADBEEF, 32'hDEADBEEF);
      // both requesting for four accesses (first tie: last_grant is B)
      add_access(1,0,1,0, 1,1, 32'h11111111, 0,    0, 32'hDEADBEEF, 32'h11111111);
      add_access(1,0,1,0, 1,1, 32'h22222222, TIE2, 0, 32'h11111111, 32'h22222222);
      add_access(1,0,1,0, 1,1, 32'h33333333, 0,    0, 32'h22222222, 32'h33333333);
      add_access(1,0,1,0, 0,0, 32'h44444444, TIE2, 0, 32'h33333333, 32'h44444444);
      // ReqB withdrawn during BUSY: access completes, AckB still pulses
      add(0,0,1,0, 32'h55555555, S_BUSY, 1,1,0,0,0, 32'h44444444);
      add(0,0,0,0, 32'h55555555, S_BUSY, 1,1,0,0,0, 32'h44444444);
      add(0,0,0,0, 32'h55555555, S_ACK,  1,0,0,0,1, 32'h55555555);
      add(0,0,0,0, 32'h55555555, S_IDLE, 1,0,0,0,0, 32'h55555555);
      // write A with WrA flipped during BUSY: latched write is used
      add(1,1,0,0, 32'h66666666, S_BUSY, 0,1,1,0,0, 32'h55555555);
      add(1,0,0,0, 32'h66666666, S_BUSY, 0,1,1,0,0, 32'h55555555);
      add(1,0,0,0, 32'h66666666, S_ACK,  0,0,0,1,0, 32'h55555555);
      add(0,0,0,0, 32'h66666666, S_IDLE, 0,0,0,0,0, 32'h55555555);
   end

   // ---------------- stimulus ----------------
   initial begin
      // reset values
      #12;
      chk1("rst st0", st == S_IDLE, 1'b1);
      chk1("rst sel", sel, 1'b0);
      chk1("rst en", mem_en, 1'b0);
      chk1("rst wr", mem_wr, 1'b0);
      chk1("rst ack_a", ack_a, 1'b0);
      chk1("rst ack_b", ack_b, 1'b0);
      chk32("rst rdata", rdata, 32'h0);
      @(negedge clk);
      rst_n = 1'b1;

      // table-driven vectors
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         req_a = vecs[i].ra; wr_a = vecs[i].wa;
         req_b = vecs[i].rb; wr_b = vecs[i].wb;
         mrd   = vecs[i].mrd;
         @(posedge clk);
         #1;
         chk32($sformatf("v%0d state", i), {30'b0, st}, {30'b0, vecs[i].st});
         chk1($sformatf("v%0d sel", i), sel, vecs[i].sel);
         chk1($sformatf("v%0d mem_en", i), mem_en, vecs[i].en);
         chk1($sformatf("v%0d mem_wr", i), mem_wr, vecs[i].wr);
         chk1($sformatf("v%0d ack_a", i), ack_a, vecs[i].aa);
         chk1($sformatf("v%0d ack_b", i), ack_b, vecs[i].ab);
         chk32($sformatf("v%0d rdata", i), rdata, vecs[i].rd);
      end

      // reset asserted in the middle of a B access
      @(negedge clk);
      req_b = 1; wr_b = 0; mrd = 32'hCAFEF00D;
      @(posedge clk); #1;
      chk1("mid busy en", mem_en, 1'b1);
      chk1("mid busy sel", sel, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk1("async rst en", mem_en, 1'b0);
      chk1("async rst sel", sel, 1'b0);
      chk32("async rst rdata", rdata, 32'h0);
      chk1("async rst state", st == S_IDLE, 1'b1);
      req_b = 0;
      @(posedge clk); #1;
      chk1("rst hold ack_b", ack_b, 1'b0);
      @(posedge clk); #1;
      chk1("rst hold ack_b2", ack_b, 1'b0);
      @(negedge clk);
      rst_n = 1'b1;
      req_a = 1; wr_a = 0; mrd = 32'h0BADC0DE;
      @(posedge clk); #1;
      chk1("post rst grant sel", sel, 1'b0);
      chk1("post rst grant en", mem_en, 1'b1);
      @(posedge clk); #1;
      chk1("post rst busy en", mem_en, 1'b1);
      chk1("post rst no ack yet", ack_a, 1'b0);
      @(posedge clk); #1;
      chk1("post rst ack_a", ack_a, 1'b1);
      chk1("post rst en off", mem_en, 1'b0);
      chk32("post rst rdata", rdata, 32'h0BADC0DE);
      @(negedge clk);
      req_a = 0;
      @(posedge clk); #1;
      chk1("post rst ack_a drop", ack_a, 1'b0);

      // MEM_LATENCY=1 instance: ReqA held, 3-cycle access period
      for (int k = 0; k < 6; k++) begin
         logic       e_en, e_ack;
         logic [1:0] e_st;
         logic [31:0] e_rd;
         @(negedge clk);
         req_a1 = (k < 5);
         mrd1   = (k < 3) ? 32'h77777777 : 32'h88888888;
         @(posedge clk); #1;
         e_en  = (k == 0) || (k == 3);
         e_ack = (k == 1) || (k == 4);
         e_st  = (k % 3 == 0) ? S_BUSY : ((k % 3 == 1) ? S_ACK : S_IDLE);
         e_rd  = (k == 0) ? 32'h0 : ((k < 4) ? 32'h77777777 : 32'h88888888);
         chk1($sformatf("l1 k%0d mem_en", k), mem_en1, e_en);
         chk1($sformatf("l1 k%0d ack_a", k), ack_a1, e_ack);
         chk1($sformatf("l1 k%0d ack_b", k), ack_b1, 1'b0);
         chk32($sformatf("l1 k%0d state", k), {30'b0, st1}, {30'b0, e_st});
         chk32($sformatf("l1 k%0d rdata", k), rdata1, e_rd);
      end

      repeat (2) @(posedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Two-requester arbiter for one shared 32-bit memory port, e.g. instruction fetch (A) and load/store (B) on a single-ported memory.
- Drives the select line of the external 32-bit 2:1 muxes that steer address and write data into the memory.
- Sequences each access for a fixed memory latency, returns read data and a one-cycle acknowledge to the granted requester.

Parameters:
- MEM_LATENCY, 2, memory access duration in cycles (legal range 1..15).
- CNT_W, 4, width of the latency down-counter.

Ports:
- Clk in 1: system clock, rising edge.
- Reset_n in 1: asynchronous active-low reset.
- ReqA in 1: requester A access request, level, held until AckA.
- WrA in 1: requester A write (1) / read (0), valid with ReqA.
- ReqB in 1: requester B access request, level, held until AckB.
- WrB in 1: requester B write/read, valid with ReqB.
- MemRData in 32: read data from memory, valid on the last BUSY cycle.
- Sel out 1: mux select; 0 selects A, 1 selects B.
- MemEn out 1: memory enable, high for exactly MEM_LATENCY cycles per access.
- MemWr out 1: write strobe for the granted requester, qualified by MemEn.
- AckA out 1: one-cycle completion pulse to A.
- AckB out 1: one-cycle completion pulse to B.
- RData out 32: captured read data, valid in the Ack cycle, held until the next capture.

Behaviour:
- Clocking and reset: one clock, Clk. Reset is asynchronous and active-low on Reset_n.
- Reset values: state IDLE; Sel=0, MemEn=0, MemWr=0, AckA=0, AckB=0, RData=0, counter=0, last_grant=B (so A wins the first tie).
- All outputs are registered.
- IDLE state:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - ReqA and ReqB together: grant the requester that is not last_grant (round-robin).
  - On grant, at the next edge: Sel=granted id, MemWr=granted Wr, MemEn=1, counter=MEM_LATENCY-1, last_grant=granted id; go to BUSY.
- BUSY state:
  - Sel and MemWr stay frozen.
  - Counter decrements each cycle while nonzero.
  - When counter==0: capture MemRData into RData (reads only; writes leave RData unchanged), pulse the granted Ack high for one cycle, drop MemEn and MemWr, go to ACK.
- ACK state:
  - One cycle; Ack is high; requests are ignored.
  - Requester must deassert Req by the edge ending this cycle.
  - Next state is IDLE.
  - Sel holds its value until the next grant.
- Throughput: MEM_LATENCY+2 cycles per access (grant, MEM_LATENCY BUSY cycles, ACK). Back-to-back alternate grants are allowed when both requesters keep requesting.
- Latency from Req seen in IDLE to Ack high: MEM_LATENCY+1 edges.
- Req withdrawn during BUSY: the access completes and the Ack is still issued.
- Req/Wr changing during BUSY: ignored; the latched values are used.
- MEM_LATENCY=1: BUSY lasts exactly one cycle, and the counter is loaded with 0.
- Reset asserted mid-access: immediate return to reset values. The in-flight access is abandoned and no Ack is issued.
- AckA and AckB are never high together. MemEn is never high outside BUSY.

Optional Feature:
- Macro: MEM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; A always wins a tie (instruction fetch first). last_grant is still updated but not consulted.
- Undefined: round-robin tie-break as specified above.
- Single-requester behaviour is identical in both modes.

Decomposition:
- Shared package holds:
  - state encoding localparams: IDLE=2'd0, BUSY=2'd1, ACK=2'd2;
  - requester ids: REQ_A=1'b0, REQ_B=1'b1;
  - DATA_W=32.
- One natural sub-module, arb_rr2: the combinational 2-way tie-break (inputs ReqA, ReqB, last_grant; output grant id). It is swapped to fixed priority under the macro.
- The FSM and counter stay in the top module.

Test Plan:
- Single read A, MEM_LATENCY=2, MemRData=32'hDEADBEEF:
  - Sel=0, MemEn high 2 cycles, MemWr=0;
  - AckA one cycle on the 3rd edge after grant, with RData=32'hDEADBEEF;
  - AckB never asserts.
- Single write B, WrB=1:
  - Sel=1, MemWr=1 for 2 cycles with MemEn;
  - AckB pulse; RData keeps its prior value.
- ReqA and ReqB held together for 4 accesses:
  - Grants A,B,A,B (round-robin);
  - with MEM_ARB_FIXED_PRIO_EN, grants A,A,A,A until ReqA drops.
- ReqB drops during BUSY: access completes, AckB still pulses, arbiter returns to IDLE.
- Reset_n low mid-BUSY: all outputs 0 asynchronously, no Ack. After release, a new ReqA is served normally.
- MEM_LATENCY=1 rebuild: MemEn high exactly 1 cycle, 3-cycle access period, Ack timing correct.
